x7seg_scan: RTL
===============

X7SEG_SCAN -- requirements
Module: x7seg_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles per digit slot (legal range >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; it SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port data_in, input, 16, four hex nibbles, where [3:0] is the rightmost digit.
REQ-005 The block SHALL have port load, input, 1, a one-cycle request to capture data_in.
REQ-006 The block SHALL have port blank_lz, input, 1, which enables leading-zero blanking when high.
REQ-007 The block SHALL have port digit, output, 4, the nibble for the active slot, fed to the downstream 7-seg decoder.
REQ-008 The block SHALL have port an, output, 4, active-low one-hot digit enable.
REQ-009 The block SHALL have port blank, output, 1, high while the active slot is blanked.
REQ-010 The block SHALL have port pending, output, 1, high while captured data is waiting for the frame boundary.
REQ-011 The block SHALL have port frame_done, output, 1, a one-cycle pulse at each frame boundary.

Function
REQ-012 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0, and SHALL be sized as $clog2(REFRESH_DIV).
- tick SHALL be asserted in the cycle where count == REFRESH_DIV-1.
REQ-013 The slot index sel (2 bits) SHALL advance on tick: 0->1->2->3->0.
REQ-014 The frame boundary SHALL be tick with sel == 3.
- frame_done SHALL be registered and high for exactly the cycle after the boundary.
REQ-015 The display register disp (16 bits) SHALL drive the scan, and digit SHALL be disp[4*sel+3 : 4*sel].
REQ-016 an SHALL be ~(4'b0001 << sel) unless the slot is blanked, in which case an SHALL be 4'b1111.
- sel == 0 SHALL give an = 4'b1110.
REQ-017 Load handling:
- load SHALL capture data_in into the pending register pend and set pending = 1.
- Multiple loads before a boundary SHALL be resolved last-wins.
REQ-018 At the frame boundary, if pending = 1: disp <= pend, pending <= 0.
- disp SHALL change only at boundaries (no tearing within a frame).
REQ-019 If load and the boundary occur in the same cycle: disp <= data_in, pending <= 0, and pend SHALL be updated to data_in.
REQ-020 With blank_lz = 1, slot k (k = 1..3) SHALL be blanked iff disp[15:4k] == 0.
- Slot 0 SHALL never be blanked.
- With blank_lz = 0, no slot SHALL be blanked.
REQ-021 blank, an, and digit SHALL be combinational from sel, disp, and blank_lz, with no added latency.
- A change to blank_lz SHALL take effect in the same cycle.

Reset
REQ-022 While rst_n = 0, the block SHALL hold: count=0, sel=0, disp=0, pend=0, pending=0, frame_done=0.
- The resulting outputs SHALL be digit=4'h0, an=4'b1110, blank=0.
REQ-023 Reset assertion mid-frame SHALL take effect immediately (asynchronously), and a pending load SHALL be discarded.
REQ-024 After rst_n deasserts, the first tick SHALL occur REFRESH_DIV cycles after the first active edge.

Verification (REFRESH_DIV=4)
REQ-025 The bench SHALL cover the following scenarios:
- Reset: assert rst_n=0 while sel=2 -> same cycle an=1110, digit=0, pending=0, frame_done=0.
- Scan: load 16'h1234 with pulse -> pending=1 until the 4th tick. Then frame_done pulses once, and slots show digit 4/an 1110, 3/1101, 2/1011, 1/0111, each for 4 cycles, repeating.
- Last-wins: load 16'hAAAA then 16'h5555 within one frame -> next frame shows 5,5,5,5, and AAAA never appears.
- Simultaneous: load 16'h00F0 in the boundary cycle -> the next slot shows digit 0 from 00F0, and pending stays 0.
- Blanking: blank_lz=1, disp=16'h0045 -> slots 2,3 give an=1111 and blank=1; slots 0,1 show 5,4. With disp=16'h0000, only slot 0 is lit, showing 0.
- Wrap: run 3 frames with no load -> frame_done period is exactly 16 cycles, and disp is unchanged.

Source files
------------

// File: rtl/x7seg_scan.sv
// Time-multiplexed driver for a 4-digit 7-segment display with frame-synchronous
// updates and optional leading-zero blanking.
module x7seg_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        blank,
    output logic        pending,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] count;
    logic [1:0]    sel;
    logic [15:0]   disp;
    logic [15:0]   pend;
    logic          tick;
    logic          boundary;
    logic          blanked;

    assign tick     = (count == LAST);
    assign boundary = tick && (sel == 2'd3);

    // disp only moves at the frame boundary so a frame never mixes two values;
    // a load landing exactly on the boundary bypasses pend and goes straight in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            sel        <= 2'd0;
            disp       <= 16'h0000;
            pend       <= 16'h0000;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            count      <= tick ? '0 : count + CW'(1);
            frame_done <= boundary;
            if (tick) begin
                sel <= sel + 2'd1;
            end
            if (load) begin
                pend <= data_in;
            end
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    disp <= data_in;
                end else if (pending) begin
                    disp <= pend;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // A slot is a leading zero when it and every digit to its left are zero.
    always_comb begin
        blanked = 1'b0;
        if (blank_lz) begin
            case (sel)
                2'd1:    blanked = (disp[15:4] == 12'h000);
                2'd2:    blanked = (disp[15:8] == 8'h00);
                2'd3:    blanked = (disp[15:12] == 4'h0);
                default: blanked = 1'b0;
            endcase
        end
    end

    assign digit = disp[{sel, 2'b00} +: 4];
    assign blank = blanked;
    assign an    = blanked ? 4'b1111 : ~(4'b0001 << sel);

endmodule
